du_rx_loader: RTL and testbench
===============================

# du_rx_loader

Parametrised debug-unit receive decoder: it sits between the UART receiver and the instruction memory / debug control FSM. It parses a framed byte stream of commands. A LOAD command delivers a word count, then that many instructions of N_BYTES bytes each, then an XOR checksum. A MODE command delivers a single operating-mode byte. Instruction words are assembled in a configurable byte order and written to memory as single-cycle write strobes, with per-frame timeout and error reporting.

## Interface
- NB_BYTE, 8, bits per UART byte
- N_BYTES, 4, bytes per instruction word (≥1); NB_DATA = NB_BYTE*N_BYTES is derived
- ADDR_W, 8, write-address width; address wraps modulo 2^ADDR_W
- TIMEOUT, 1023, max idle cycles between bytes inside a frame; 0 disables the timeout
- BIG_ENDIAN, 0, 0: first byte lands in bits [NB_BYTE-1:0]; 1: first byte lands in the MSB byte
- CMD_LOAD, 8'h01, LOAD command byte
- CMD_MODE, 8'h02, MODE command byte
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid
- i_rx_data  in  NB_BYTE  received byte
- i_abort  in  1  forces return to IDLE; no error is raised
- o_wr_en  out  1  one-cycle instruction-memory write strobe
- o_wr_addr  out  ADDR_W  word index of the write
- o_wr_data  out  NB_DATA  assembled instruction
- o_count  out  NB_BYTE  word count of the current or last LOAD
- o_load_done  out  1  level; program loaded with a good checksum
- o_mode  out  NB_BYTE  last mode byte received
- o_mode_valid  out  1  one-cycle pulse on a new mode byte
- o_error  out  2  sticky code: 00 none, 01 checksum, 10 timeout, 11 bad command
- o_busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, COUNT, DATA, CSUM, MODE. Only cycles with i_rx_valid=1 consume a byte.
- IDLE, receiving a byte:
  - CMD_LOAD: go to COUNT, clear o_error, clear o_load_done, clear the checksum accumulator.
  - CMD_MODE: go to MODE, clear o_error.
  - Any other value: o_error=11, stay in IDLE.
- COUNT: o_count ← byte; acc ^= byte; word index ← 0; byte counter ← 0. Next state is CSUM if count==0, else DATA.
- DATA: the byte is shifted into the word per BIG_ENDIAN; acc ^= byte. On byte N_BYTES-1:
  - Assert o_wr_en with o_wr_addr = index[ADDR_W-1:0] and o_wr_data = the full word.
  - Increment index, reset the byte counter.
  - If index+1 == count, go to CSUM.
- CSUM: if byte == acc, set o_load_done=1; otherwise o_error=01. Return to IDLE.
- MODE: o_mode ← byte, pulse o_mode_valid, return to IDLE.
- Timeout counter: clears on every consumed byte and on entry to IDLE, and counts while not in IDLE. On reaching TIMEOUT (when TIMEOUT ≠ 0): go to IDLE, set o_error=10, leave o_load_done=0. Words already written stay written.
- i_abort: go to IDLE and clear the byte counter and timeout counter. o_error, o_load_done, o_count and o_mode are unchanged.
- Priority: i_reset > i_abort > timeout > byte consumption.
- o_wr_data and o_wr_addr hold their last values when o_wr_en=0.

## Timing
- Reset values:
  - o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_count=0
  - o_load_done=0, o_mode=0, o_mode_valid=0, o_error=00, o_busy=0
  - state=IDLE; all counters and the accumulator are 0.
- All outputs are registered. Effects of a byte consumed at edge k are visible after edge k: o_wr_en, o_mode_valid, o_load_done, o_error and state all update in the same cycle.
- o_wr_en and o_mode_valid are high for exactly one cycle per event.
- Back-to-back i_rx_valid on consecutive cycles is supported with no byte loss.
- A timeout fires in the cycle the counter equals TIMEOUT, i.e. TIMEOUT cycles after the last byte.
- A word count above 2^ADDR_W wraps the addresses, e.g. ADDR_W=2 with count=5 writes to 0,1,2,3,0.
- Reset mid-frame: any partial word is discarded, no write occurs, and the block returns to IDLE.

## Test plan
- LOAD, LE, N_BYTES=4. Send 01 02 44 33 22 11 DD CC BB AA 46 -> writes addr0=0x11223344 and addr1=0xAABBCCDD; o_load_done=1; o_error=00; o_count=2.
- Same stream with BIG_ENDIAN=1 -> addr0=0x44332211, addr1=0xDDCCBBAA; o_load_done=1.
- Same stream with checksum byte 0x47 -> both writes occur; o_load_done=0; o_error=01; o_busy=0.
- Send 01 00 00 -> no writes, o_load_done=1. Then send 02 5A -> o_mode=0x5A with a one-cycle o_mode_valid; o_load_done stays 1.
- TIMEOUT=16. Send 01 02 44 33, then silence -> no write, o_error=10, IDLE 16 cycles after the last byte. Send 7F -> o_error=11. Send 01 -> o_error=00.
- Assert i_abort in the same cycle as the final data byte -> no write, o_busy=0, o_error unchanged. Assert i_reset mid-DATA -> all outputs return to their reset values.

Source files
------------

// File: rtl/du_rx_loader_if.sv
// rtl/du_rx_loader_if.sv - byte-receive and instruction-write bundle for du_rx_loader
interface du_rx_loader_if #(
  parameter int NB_BYTE = 8,
  parameter int N_BYTES = 4,
  parameter int ADDR_W  = 8
);
  localparam int NB_DATA = NB_BYTE * N_BYTES;

  logic               i_rx_valid;
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_abort;
  logic               o_wr_en;
  logic [ADDR_W-1:0]  o_wr_addr;
  logic [NB_DATA-1:0] o_wr_data;
  logic [NB_BYTE-1:0] o_count;
  logic               o_load_done;
  logic [NB_BYTE-1:0] o_mode;
  logic               o_mode_valid;
  logic [1:0]         o_error;
  logic               o_busy;

  modport slave (
    input  i_rx_valid, i_rx_data, i_abort,
    output o_wr_en, o_wr_addr, o_wr_data, o_count, o_load_done,
           o_mode, o_mode_valid, o_error, o_busy
  );

  modport master (
    output i_rx_valid, i_rx_data, i_abort,
    input  o_wr_en, o_wr_addr, o_wr_data, o_count, o_load_done,
           o_mode, o_mode_valid, o_error, o_busy
  );
endinterface

// File: rtl/du_rx_loader.sv
// rtl/du_rx_loader.sv - debug-unit frame decoder: LOAD (count, words, xor checksum) and MODE commands
module du_rx_loader #(
  parameter int                 NB_BYTE    = 8,
  parameter int                 N_BYTES    = 4,
  parameter int                 ADDR_W     = 8,
  parameter int                 TIMEOUT    = 1023,
  parameter bit                 BIG_ENDIAN = 1'b0,
  parameter logic [NB_BYTE-1:0] CMD_LOAD   = 8'h01,
  parameter logic [NB_BYTE-1:0] CMD_MODE   = 8'h02
) (
  input  logic          i_clock,
  input  logic          i_reset,
  du_rx_loader_if.slave bus
);
  localparam int NB_DATA = NB_BYTE * N_BYTES;
  localparam int BW      = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_CSUM, S_MODE} state_t;

  state_t             state, state_next;
  logic [BW-1:0]      byte_cnt;
  logic [NB_BYTE-1:0] word_idx;
  logic [NB_BYTE-1:0] acc;
  logic [NB_DATA-1:0] word, word_next;
  logic [TW-1:0]      timer;
  logic [BW-1:0]      lane;

  logic timeout_hit;
  logic ld_start, mode_start, bad_cmd, take_count, take_data, word_done, take_csum, take_mode;

  // The transition happens on the edge where the idle counter would reach TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && (state != S_IDLE) && (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    ld_start   = 1'b0;
    mode_start = 1'b0;
    bad_cmd    = 1'b0;
    take_count = 1'b0;
    take_data  = 1'b0;
    word_done  = 1'b0;
    take_csum  = 1'b0;
    take_mode  = 1'b0;
    if (bus.i_abort || timeout_hit) begin
      state_next = S_IDLE;
    end else if (bus.i_rx_valid) begin
      unique case (state)
        S_IDLE: begin
          if (bus.i_rx_data == CMD_LOAD) begin
            ld_start   = 1'b1;
            state_next = S_COUNT;
          end else if (bus.i_rx_data == CMD_MODE) begin
            mode_start = 1'b1;
            state_next = S_MODE;
          end else begin
            bad_cmd = 1'b1;
          end
        end
        S_COUNT: begin
          take_count = 1'b1;
          state_next = (bus.i_rx_data == '0) ? S_CSUM : S_DATA;
        end
        S_DATA: begin
          take_data = 1'b1;
          if (byte_cnt == BW'(N_BYTES - 1)) begin
            word_done = 1'b1;
            if (NB_BYTE'(word_idx + 1'b1) == bus.o_count) state_next = S_CSUM;
          end
        end
        S_CSUM: begin
          take_csum  = 1'b1;
          state_next = S_IDLE;
        end
        S_MODE: begin
          take_mode  = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Byte lane for the incoming data byte; lane 0 is bits [NB_BYTE-1:0].
  always_comb begin
    lane      = BIG_ENDIAN ? (BW'(N_BYTES - 1) - byte_cnt) : byte_cnt;
    word_next = word;
    for (int i = 0; i < N_BYTES; i++) begin
      if (BW'(i) == lane) word_next[i*NB_BYTE +: NB_BYTE] = bus.i_rx_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      byte_cnt         <= '0;
      word_idx         <= '0;
      acc              <= '0;
      word             <= '0;
      timer            <= '0;
      bus.o_wr_en      <= 1'b0;
      bus.o_wr_addr    <= '0;
      bus.o_wr_data    <= '0;
      bus.o_count      <= '0;
      bus.o_load_done  <= 1'b0;
      bus.o_mode       <= '0;
      bus.o_mode_valid <= 1'b0;
      bus.o_error      <= 2'b00;
      bus.o_busy       <= 1'b0;
    end else begin
      bus.o_wr_en      <= 1'b0;
      bus.o_mode_valid <= 1'b0;
      bus.o_busy       <= (state_next != S_IDLE);

      if (state_next == S_IDLE || bus.i_rx_valid) timer <= '0;
      else                                        timer <= timer + 1'b1;

      if (bus.i_abort) begin
        byte_cnt <= '0;
      end else if (timeout_hit) begin
        byte_cnt    <= '0;
        bus.o_error <= 2'b10;
      end

      if (bad_cmd) bus.o_error <= 2'b11;
      if (mode_start) bus.o_error <= 2'b00;
      if (ld_start) begin
        bus.o_error     <= 2'b00;
        bus.o_load_done <= 1'b0;
        acc             <= '0;
        word            <= '0;
      end
      if (take_count) begin
        bus.o_count <= bus.i_rx_data;
        acc         <= acc ^ bus.i_rx_data;
        word_idx    <= '0;
        byte_cnt    <= '0;
      end
      if (take_data) begin
        acc  <= acc ^ bus.i_rx_data;
        word <= word_next;
        if (word_done) begin
          bus.o_wr_en   <= 1'b1;
          bus.o_wr_addr <= ADDR_W'(word_idx);
          bus.o_wr_data <= word_next;
          word_idx      <= word_idx + 1'b1;
          byte_cnt      <= '0;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
      if (take_csum) begin
        if (bus.i_rx_data == acc) bus.o_load_done <= 1'b1;
        else                      bus.o_error     <= 2'b01;
      end
      if (take_mode) begin
        bus.o_mode       <= bus.i_rx_data;
        bus.o_mode_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_du_rx_loader.sv
// tb/tb_du_rx_loader.sv - scoreboard bench for du_rx_loader, little- and big-endian instances
module tb_du_rx_loader;
  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clock = ~i_clock;

  du_rx_loader_if #(.NB_BYTE(8), .N_BYTES(4), .ADDR_W(2)) bl ();
  du_rx_loader_if #(.NB_BYTE(8), .N_BYTES(4), .ADDR_W(2)) bb ();

  du_rx_loader #(.NB_BYTE(8), .N_BYTES(4), .ADDR_W(2), .TIMEOUT(16), .BIG_ENDIAN(1'b0))
    dut_le (.i_clock(i_clock), .i_reset(i_reset), .bus(bl));
  du_rx_loader #(.NB_BYTE(8), .N_BYTES(4), .ADDR_W(2), .TIMEOUT(16), .BIG_ENDIAN(1'b1))
    dut_be (.i_clock(i_clock), .i_reset(i_reset), .bus(bb));

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] q_le[$];
  logic [33:0] q_be[$];
  logic [7:0]  q_mode[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic abort = 1'b0);
    bl.i_rx_valid = 1'b1; bl.i_rx_data = b; bl.i_abort = abort;
    bb.i_rx_valid = 1'b1; bb.i_rx_data = b; bb.i_abort = abort;
    @(posedge i_clock); #1;
    bl.i_rx_valid = 1'b0; bl.i_abort = 1'b0;
    bb.i_rx_valid = 1'b0; bb.i_abort = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  always @(negedge i_clock) begin
    if (!i_reset) begin
      if (bl.o_wr_en) begin
        if (q_le.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL le_write unexpected: addr %0h data %0h", bl.o_wr_addr, bl.o_wr_data);
        end else check("le_write", {30'd0, bl.o_wr_addr, bl.o_wr_data}, {30'd0, q_le.pop_front()});
      end
      if (bb.o_wr_en) begin
        if (q_be.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL be_write unexpected: addr %0h data %0h", bb.o_wr_addr, bb.o_wr_data);
        end else check("be_write", {30'd0, bb.o_wr_addr, bb.o_wr_data}, {30'd0, q_be.pop_front()});
      end
      if (bl.o_mode_valid) begin
        if (q_mode.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL mode_valid unexpected: mode %0h", bl.o_mode);
        end else check("mode_pulse", {56'd0, bl.o_mode}, {56'd0, q_mode.pop_front()});
      end
    end
  end

  initial begin
    bl.i_rx_valid = 1'b0; bl.i_rx_data = '0; bl.i_abort = 1'b0;
    bb.i_rx_valid = 1'b0; bb.i_rx_data = '0; bb.i_abort = 1'b0;
    repeat (3) @(posedge i_clock);
    #1 i_reset = 1'b0;

    check("rst_busy", bl.o_busy, 0);
    check("rst_error", bl.o_error, 0);
    check("rst_load_done", bl.o_load_done, 0);
    check("rst_count", bl.o_count, 0);
    check("rst_wr", {bl.o_wr_en, bl.o_wr_addr, bl.o_wr_data}, 0);
    check("rst_mode", {bl.o_mode, bl.o_mode_valid}, 0);

    // Two-word LOAD, good checksum
    q_le.push_back({2'd0, 32'h11223344}); q_le.push_back({2'd1, 32'hAABBCCDD});
    q_be.push_back({2'd0, 32'h44332211}); q_be.push_back({2'd1, 32'hDDCCBBAA});
    send_list('{8'h01, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h46});
    check("load_done_le", bl.o_load_done, 1);
    check("load_done_be", bb.o_load_done, 1);
    check("load_error", bl.o_error, 0);
    check("load_count", bl.o_count, 2);
    check("load_busy", bl.o_busy, 0);

    // Same stream, bad checksum
    q_le.push_back({2'd0, 32'h11223344}); q_le.push_back({2'd1, 32'hAABBCCDD});
    q_be.push_back({2'd0, 32'h44332211}); q_be.push_back({2'd1, 32'hDDCCBBAA});
    send_list('{8'h01, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h47});
    check("csum_load_done", bl.o_load_done, 0);
    check("csum_error", bl.o_error, 2'b01);
    check("csum_busy", bl.o_busy, 0);

    // Zero-length LOAD, then MODE
    send_list('{8'h01, 8'h00, 8'h00});
    check("zero_load_done", bl.o_load_done, 1);
    check("zero_count", bl.o_count, 0);
    q_mode.push_back(8'h5A);
    send_list('{8'h02, 8'h5A});
    check("mode_value", bl.o_mode, 8'h5A);
    check("mode_keeps_done", bl.o_load_done, 1);
    idle(2);
    check("mode_pulse_len", bl.o_mode_valid, 0);

    // Timeout 16 cycles after the last byte
    send_list('{8'h01, 8'h02, 8'h44, 8'h33});
    idle(15);
    check("to_busy_before", bl.o_busy, 1);
    idle(1);
    check("to_busy_after", bl.o_busy, 0);
    check("to_error", bl.o_error, 2'b10);
    check("to_load_done", bl.o_load_done, 0);
    send(8'h7F);
    check("bad_cmd_error", bl.o_error, 2'b11);
    send(8'h01);
    check("load_clears_error", bl.o_error, 2'b00);
    check("load_busy", bl.o_busy, 1);
    bl.i_abort = 1'b1; bb.i_abort = 1'b1;
    idle(1);
    bl.i_abort = 1'b0; bb.i_abort = 1'b0;
    check("abort_idle", bl.o_busy, 0);

    // Abort together with the final data byte: only the first word lands
    q_le.push_back({2'd0, 32'h11223344});
    q_be.push_back({2'd0, 32'h44332211});
    send_list('{8'h01, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB});
    send(8'hAA, 1'b1);
    check("abort_busy", bl.o_busy, 0);
    check("abort_error", bl.o_error, 2'b00);
    check("abort_count", bl.o_count, 2);
    check("abort_load_done", bl.o_load_done, 0);

    // Count 5 with 2-bit addresses wraps back to 0
    q_le.push_back({2'd0, 32'h13121110}); q_be.push_back({2'd0, 32'h10111213});
    q_le.push_back({2'd1, 32'h23222120}); q_be.push_back({2'd1, 32'h20212223});
    q_le.push_back({2'd2, 32'h33323130}); q_be.push_back({2'd2, 32'h30313233});
    q_le.push_back({2'd3, 32'h43424140}); q_be.push_back({2'd3, 32'h40414243});
    q_le.push_back({2'd0, 32'h53525150}); q_be.push_back({2'd0, 32'h50515253});
    send_list('{8'h01, 8'h05,
                8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23,
                8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41, 8'h42, 8'h43,
                8'h50, 8'h51, 8'h52, 8'h53, 8'h05});
    check("wrap_load_done", bl.o_load_done, 1);
    check("wrap_count", bl.o_count, 5);

    // Reset in the middle of DATA
    send_list('{8'h02, 8'hC3});
    q_mode.push_back(8'hC3);
    send_list('{8'h01, 8'h02, 8'h44, 8'h33});
    i_reset = 1'b1;
    idle(1);
    i_reset = 1'b0;
    check("mid_rst_busy", bl.o_busy, 0);
    check("mid_rst_count", bl.o_count, 0);
    check("mid_rst_mode", bl.o_mode, 0);
    check("mid_rst_wr", {bl.o_wr_en, bl.o_wr_addr, bl.o_wr_data}, 0);
    check("mid_rst_flags", {bl.o_load_done, bl.o_error}, 0);
    idle(4);

    check("le_queue_empty", q_le.size(), 0);
    check("be_queue_empty", q_be.size(), 0);
    check("mode_queue_empty", q_mode.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
